// File: rtl/mdu_div_seq.sv
// mdu_div_seq: sequential radix-2 restoring RV64M divider with valid/ready in and out
module mdu_div_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        div,
  input  logic        divu,
  input  logic        rem,
  input  logic        remu,
  input  logic        word,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic is_rem_q, is_rem_d, word_q, word_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic out_valid_q, out_valid_d;
  logic [6:0] cnt_q, cnt_d;
  logic [63:0] dvd_q, dvd_d, dvs_q, dvs_d, acc_q, acc_d, result_q, result_d;
  logic sgn, s1, s2, dz, ovf, none;
  logic [63:0] a, b, abs_a, abs_b, spec_val, acc_n, dvd_n, qv, rv;
  logic [64:0] pr;
  function automatic logic [63:0] fix(input logic w, input logic [63:0] v);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction
  assign sgn = div | rem;
  assign a = word ? {{32{sgn & src1[31]}}, src1[31:0]} : src1;
  assign b = word ? {{32{sgn & src2[31]}}, src2[31:0]} : src2;
  assign s1 = sgn & a[63];
  assign s2 = sgn & b[63];
  assign abs_a = s1 ? -a : a;
  assign abs_b = s2 ? -b : b;
  assign dz = b == 64'd0;
  assign ovf = sgn & (a == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) & (&b);
  assign none = !(div | divu | rem | remu);
  assign spec_val = none ? 64'd0 : dz ? ((rem | remu) ? a : '1) : ((rem | remu) ? 64'd0 : a);
  assign pr = {acc_q, dvd_q[63]} - {1'b0, dvs_q};
  assign acc_n = pr[64] ? {acc_q[62:0], dvd_q[63]} : pr[63:0];
  assign dvd_n = {dvd_q[62:0], !pr[64]};
  assign qv = qneg_q ? -dvd_n : dvd_n;
  assign rv = rneg_q ? -acc_n : acc_n;
  always_comb begin
    state_d = state_q;
    is_rem_d = is_rem_q;
    word_d = word_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    out_valid_d = out_valid_q;
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    acc_d = acc_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      is_rem_d = rem | remu;
      word_d = word;
      qneg_d = s1 ^ s2;
      rneg_d = s1;
      if (dz || ovf || none) begin
        state_d = DONE;
        out_valid_d = 1'b1;
        result_d = fix(word, spec_val);
      end else begin
        state_d = CALC;
        cnt_d = word ? 7'd32 : 7'd64;
        acc_d = 64'd0;
        dvd_d = word ? {abs_a[31:0], 32'd0} : abs_a;
        dvs_d = abs_b;
      end
    end else if (state_q == CALC) begin
      acc_d = acc_n;
      dvd_d = dvd_n;
      cnt_d = cnt_q - 7'd1;
      if (cnt_q == 7'd1) begin
        state_d = DONE;
        out_valid_d = 1'b1;
        result_d = fix(word_q, is_rem_q ? rv : qv);
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      is_rem_q <= 1'b0;
      word_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q <= 7'd0;
      dvd_q <= 64'd0;
      dvs_q <= 64'd0;
      acc_q <= 64'd0;
      result_q <= 64'd0;
    end else begin
      state_q <= state_d;
      is_rem_q <= is_rem_d;
      word_q <= word_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      out_valid_q <= out_valid_d;
      cnt_q <= cnt_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      acc_q <= acc_d;
      result_q <= result_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign result = result_q;
endmodule

// File: tb/tb_mdu_div_seq.sv
// tb_mdu_div_seq: directed vector bench for mdu_div_seq
module tb_mdu_div_seq;
  logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready;
  logic div = 1'b0, divu = 1'b0, rem = 1'b0, remu = 1'b0, word = 1'b0;
  logic [63:0] src1 = 64'd0, src2 = 64'd0, result;
  logic flush = 1'b0, out_valid, out_ready = 1'b1;
  int errors = 0, checks = 0;
  localparam logic [3:0] D = 4'b1000, DU = 4'b0100, R = 4'b0010, RU = 4'b0001, NONE = 4'b0000;
  typedef struct {logic [3:0] op; logic w; logic [63:0] a, b, exp; int lat;} vec_t;
  vec_t v[$];
  mdu_div_seq dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .div(div), .divu(divu), .rem(rem), .remu(remu), .word(word),
    .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    {div, divu, rem, remu} = op;
    word = w;
    src1 = a;
    src2 = b;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    {div, divu, rem, remu} = 4'($urandom);
    word = 1'($urandom);
    src1 = {$urandom, $urandom};
    src2 = {$urandom, $urandom};
  endtask
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask
  task automatic run_vec(input string tag, input vec_t t);
    int n;
    chk({tag, " in_ready before"}, 64'(in_ready), 64'd1);
    drive(t.op, t.w, t.a, t.b);
    wait_valid(n);
    chk({tag, " latency"}, 64'(n), 64'(t.lat));
    chk({tag, " result"}, result, t.exp);
    @(posedge clock);
    #1;
    chk({tag, " out_valid after handshake"}, 64'(out_valid), 64'd0);
  endtask
  task automatic watch_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clock);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk({tag, " out_valid stayed low"}, 64'(seen), 64'd0);
  endtask
  initial begin
    int n;
    v.push_back('{DU, 1'b0, 64'd100, 64'd7, 64'd14, 65});
    v.push_back('{RU, 1'b0, 64'd100, 64'd7, 64'd2, 65});
    v.push_back('{D, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65});
    v.push_back('{R, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65});
    v.push_back('{R, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65});
    v.push_back('{D, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 65});
    v.push_back('{R, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 65});
    v.push_back('{DU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65});
    v.push_back('{RU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 65});
    v.push_back('{D, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    v.push_back('{RU, 1'b0, 64'd5, 64'd0, 64'd5, 1});
    v.push_back('{D, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1});
    v.push_back('{R, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1});
    v.push_back('{D, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1});
    v.push_back('{DU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33});
    v.push_back('{DU, 1'b1, 64'd100, 64'd7, 64'd14, 33});
    v.push_back('{R, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33});
    v.push_back('{D, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33});
    v.push_back('{R, 1'b1, 64'd7, 64'h1_0000_0000, 64'd7, 1});
    v.push_back('{NONE, 1'b0, 64'd5, 64'd3, 64'd0, 1});
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", result, 64'd0);
    foreach (v[i]) run_vec($sformatf("vec%0d", i), v[i]);
    out_ready = 1'b0;
    drive(DU, 1'b0, 64'd100, 64'd7);
    wait_valid(n);
    chk("bp latency", 64'(n), 64'd65);
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("bp hold out_valid %0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp hold result %0d", k), result, 64'd14);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("bp release out_valid", 64'(out_valid), 64'd0);
    chk("bp release in_ready", 64'(in_ready), 64'd1);
    drive(DU, 1'b0, 64'd100, 64'd7);
    repeat (19) @(posedge clock);
    #1;
    chk("flush calc in_ready before", 64'(in_ready), 64'd0);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush calc in_ready T+21", 64'(in_ready), 64'd1);
    chk("flush calc out_valid T+21", 64'(out_valid), 64'd0);
    watch_quiet("flush calc", 80);
    run_vec("after flush", '{R, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65});
    {div, divu, rem, remu} = DU;
    word = 1'b0;
    src1 = 64'd100;
    src2 = 64'd7;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush accept in_ready", 64'(in_ready), 64'd1);
    watch_quiet("flush accept", 70);
    drive(D, 1'b0, 64'd1000, 64'd3);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("mid reset in_ready", 64'(in_ready), 64'd1);
    chk("mid reset out_valid", 64'(out_valid), 64'd0);
    chk("mid reset result", result, 64'd0);
    watch_quiet("mid reset", 70);
    out_ready = 1'b0;
    drive(D, 1'b0, 64'd5, 64'd0);
    wait_valid(n);
    chk("done flush latency", 64'(n), 64'd1);
    chk("done flush result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("done flush out_valid", 64'(out_valid), 64'd0);
    chk("done flush in_ready", 64'(in_ready), 64'd1);
    run_vec("final", '{DU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdu_div_seq.md
# mdu_div_seq

Sequential RV64M divider for the execute stage, used in place of the single-cycle combinational divide path. It accepts div/divu/rem/remu and their W variants from EX through a valid/ready handshake. It runs a radix-2 restoring shift-subtract loop, one quotient bit per cycle, and hands the result to MEM/WB through a second valid/ready handshake. Divide-by-zero and signed overflow bypass the loop and complete in one cycle.

## Interface
- No parameters (XLEN fixed at 64).
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  EX presents an operation.
- in_ready  out  1  divider can accept; high only in IDLE.
- div, divu, rem, remu  in  1 each  op select; at most one high while in_valid.
- word  in  1  W variant: operate on src[31:0], sign-extend 32-bit result.
- src1  in  64  dividend.
- src2  in  64  divisor.
- flush  in  1  pipeline kill; aborts any in-flight op.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- result  out  64  quotient or remainder.

## Operation
- States: IDLE, CALC, DONE.
- Accept: in_valid && in_ready && !flush. Latch the op, word, signs and operands.
- Operand prep:
  - W signed: dividend = sext(src1[31:0]), divisor = sext(src2[31:0]).
  - W unsigned: zero-extend both.
  - Signed ops: take absolute values; record qneg = s1^s2 and rneg = s1.
- Special cases, evaluated at accept, go IDLE→DONE:
  - Divisor zero (in effective width): quotient = all ones; remainder = effective dividend.
  - Signed overflow (dividend = most-negative of the effective width, divisor = -1): quotient = dividend; remainder = 0.
  - No op bit set: result 0.
- Normal path goes IDLE→CALC with count = N (N = 64, or 32 if word).
  - Each cycle: partial remainder (65-bit) = {rem, dividend MSB} − divisor if non-negative, else restore.
  - Shift the quotient bit in; decrement count.
  - When count reaches 0, apply signs (negate quotient if qneg, remainder if rneg), select quotient or remainder, and go to DONE.
- W results: result = sext(value[31:0]), for divuw/remuw as well.
- DONE: out_valid=1, result held stable. Leave for IDLE on out_ready.
- Flush: from any state, go to IDLE next cycle with out_valid=0. Takes priority over accept and over the out handshake.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, in_ready 1 (first cycle after reset deasserts).
- Accept at cycle T.
  - Normal 64-bit: CALC occupies T+1..T+64; out_valid rises at T+65.
  - Normal W: out_valid rises at T+33.
  - Special case: out_valid at T+1.
- in_ready is 0 from T+1 until the cycle after the out handshake. No same-cycle re-accept.
- result and out_valid are registered. Both are stable while out_valid && !out_ready, for any duration.
- Flush in the same cycle as in_valid: no accept; in_ready stays 1 next cycle.
- Flush while in DONE with out_ready=1: no handshake is counted; out_valid=0 next cycle.
- Reset mid-CALC: IDLE next cycle, identical to power-on values.
- Operand inputs are don't-care after the accept cycle.

## Test plan
- divu src1=100, src2=7 → result 14, out_valid exactly 65 cycles after accept; the same operands with remu → 2.
- Signed sign handling:
  - div -7/2 → 0xFFFF_FFFF_FFFF_FFFD.
  - rem -7/2 → 0xFFFF_FFFF_FFFF_FFFF.
  - rem 7/-2 → 1.
- div 5/0 → 0xFFFF_FFFF_FFFF_FFFF, and remu 5/0 → 5, both at T+1.
- div 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000 at T+1; rem of the same → 0.
- W variants:
  - divw src1=0x0000_0000_8000_0000, src2=-1 → 0xFFFF_FFFF_8000_0000 at T+1.
  - divuw 0xFFFF_FFFF / 1 → 0xFFFF_FFFF_FFFF_FFFF at T+33.
- Backpressure and flush:
  - Hold out_ready=0 for 10 cycles in DONE: result unchanged and out_valid=1 throughout.
  - Flush at T+20 of a 64-bit op: out_valid never rises and in_ready=1 at T+21.
  - A new op accepted after the flush completes correctly.
